// File: rtl/gol_row_sequencer.sv
// Double-banked Life grid store that streams rows into the cell-update array.
// Define GOL_TORUS_WRAP_EN to make the guard rows wrap vertically.
module gol_row_sequencer #(
   parameter int WIDTH   = 32,
   parameter int HEIGHT  = 32,
   parameter int CAP_OFS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_en,
   input  logic [$clog2(HEIGHT)-1:0] ld_addr,
   input  logic [WIDTH-1:0]          ld_data,
   input  logic [$clog2(HEIGHT)-1:0] rd_addr,
   output logic [WIDTH-1:0]          rd_data,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [15:0]               gen_count,
   output logic [WIDTH-1:0]          arr_in,
   input  logic [WIDTH-1:0]          arr_out
);

   localparam int AW    = $clog2(HEIGHT);
   localparam int KLAST = HEIGHT - 1 + CAP_OFS;
   localparam int KW    = $clog2(KLAST + 2);

   typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;

   state_t          state;
   logic [KW-1:0]   k;
   logic            bank_sel;
   logic [WIDTH-1:0] bank [2][HEIGHT];

   logic [AW-1:0]    in_row;
   logic [AW-1:0]    cap_row;
   logic [WIDTH-1:0] top_row;
   logic [WIDTH-1:0] bot_row;
   logic             ld_ok;
   logic             cap_ok;

   assign in_row  = AW'(k - 1'b1);
   assign cap_row = AW'(k - KW'(CAP_OFS));
   assign ld_ok   = ld_en && (state == IDLE) && (int'(ld_addr) < HEIGHT);
   assign cap_ok  = (state == RUN) && (int'(k) >= CAP_OFS) && (int'(k) <= KLAST);

`ifdef GOL_TORUS_WRAP_EN
   assign top_row = bank[bank_sel][HEIGHT-1];
   assign bot_row = bank[bank_sel][0];
`else
   assign top_row = '0;
   assign bot_row = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         bank_sel  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         gen_count <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  k     <= '0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (int'(k) == KLAST) state <= SWAP;
               else k <= k + 1'b1;
            end
            SWAP: begin
               state     <= IDLE;
               k         <= '0;
               bank_sel  <= ~bank_sel;
               gen_count <= gen_count + 16'd1;
               busy      <= 1'b0;
               done      <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Loads only land in IDLE, captures only in RUN, so they never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < HEIGHT; r++)
               bank[b][r] <= '0;
      end else begin
         if (ld_ok) bank[bank_sel][ld_addr] <= ld_data;
         if (cap_ok) bank[~bank_sel][cap_row] <= arr_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else if (int'(rd_addr) < HEIGHT) rd_data <= bank[bank_sel][rd_addr];
      else rd_data <= '0;
   end

   always_comb begin
      arr_in = '0;
      if (state == RUN) begin
         if (k == '0) arr_in = top_row;
         else if (int'(k) <= HEIGHT) arr_in = bank[bank_sel][in_row];
         else if (int'(k) == HEIGHT + 1) arr_in = bot_row;
      end
   end

endmodule

// File: tb/tb_gol_row_sequencer.sv
// Directed bench: pass-through stub on a 4-row grid, Life array model on 8 rows.
// Guard-row expectations follow GOL_TORUS_WRAP_EN.
module tb_gol_row_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       ld_en4, start4, busy4, done4;
   logic [1:0] ld_addr4, rd_addr4;
   logic [7:0] ld_data4, rd_data4, in4, out4;
   logic [15:0] gen4;

   logic       ld_en8, start8, busy8, done8;
   logic [2:0] ld_addr8, rd_addr8;
   logic [7:0] ld_data8, rd_data8, in8, out8, p1, p2;
   logic [15:0] gen8;

   int checks = 0;
   int errors = 0;

   gol_row_sequencer #(.WIDTH(8), .HEIGHT(4), .CAP_OFS(2)) d4 (
      .clk(clk), .rst(rst), .ld_en(ld_en4), .ld_addr(ld_addr4),
      .ld_data(ld_data4), .rd_addr(rd_addr4), .rd_data(rd_data4),
      .start(start4), .busy(busy4), .done(done4), .gen_count(gen4),
      .arr_in(in4), .arr_out(out4)
   );

   gol_row_sequencer #(.WIDTH(8), .HEIGHT(8), .CAP_OFS(2)) d8 (
      .clk(clk), .rst(rst), .ld_en(ld_en8), .ld_addr(ld_addr8),
      .ld_data(ld_data8), .rd_addr(rd_addr8), .rd_data(rd_data8),
      .start(start8), .busy(busy8), .done(done8), .gen_count(gen8),
      .arr_in(in8), .arr_out(out8)
   );

   // Stub: a row presented in one cycle is captured two edges later.
   always @(posedge clk) out4 <= in4;

   function automatic logic [7:0] life_row(input logic [7:0] u, m, d);
      logic [9:0] uu, mm, dd;
      int n;
      life_row = '0;
      uu = {1'b0, u, 1'b0};
      mm = {1'b0, m, 1'b0};
      dd = {1'b0, d, 1'b0};
      for (int i = 0; i < 8; i++) begin
         n = int'(uu[i]) + int'(uu[i+1]) + int'(uu[i+2]) + int'(mm[i])
           + int'(mm[i+2]) + int'(dd[i]) + int'(dd[i+1]) + int'(dd[i+2]);
         life_row[i] = (n == 3) || (m[i] && n == 2);
      end
   endfunction

   // Array model: centre row is the one presented one cycle earlier.
   always @(posedge clk) begin
      p1 <= in8;
      p2 <= p1;
   end
   assign out8 = life_row(p2, p1, in8);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ld4(input int a, input logic [7:0] v);
      ld_en4 = 1'b1; ld_addr4 = 2'(a); ld_data4 = v;
      tick();
      ld_en4 = 1'b0;
   endtask

   task automatic ld8(input int a, input logic [7:0] v);
      ld_en8 = 1'b1; ld_addr8 = 3'(a); ld_data8 = v;
      tick();
      ld_en8 = 1'b0;
   endtask

   task automatic rd4(input int a, output logic [7:0] v);
      rd_addr4 = 2'(a);
      tick();
      v = rd_data4;
   endtask

   task automatic rd8(input int a, output logic [7:0] v);
      rd_addr8 = 3'(a);
      tick();
      v = rd_data8;
   endtask

   task automatic gen8_run(output int n);
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 40) begin
         tick();
         n++;
      end
   endtask

   logic [7:0] v;
   logic [7:0] exp_seq [6];
   logic [7:0] top, bot;
   int n, pulses;

   initial begin
`ifdef GOL_TORUS_WRAP_EN
      top = 8'hD4; bot = 8'hA1;
`else
      top = 8'h00; bot = 8'h00;
`endif
      rst = 1'b1;
      ld_en4 = 0; start4 = 0; ld_addr4 = 0; ld_data4 = 0; rd_addr4 = 0;
      ld_en8 = 0; start8 = 0; ld_addr8 = 0; ld_data8 = 0; rd_addr8 = 0;
      tick();
      tick();
      chk("rst_busy", 32'(busy4), 0);
      chk("rst_done", 32'(done4), 0);
      chk("rst_gen", 32'(gen4), 0);
      chk("rst_arr_in", 32'(in4), 0);
      chk("rst_rd", 32'(rd_data4), 0);
      rst = 1'b0;
      tick();

      // Horizontal blinker in row 3 of the 8x8 grid
      for (int r = 0; r < 8; r++) ld8(r, (r == 3) ? 8'h1C : 8'h00);
      gen8_run(n);
      chk("blink_done_cycle", n, 11);
      for (int r = 0; r < 8; r++) begin
         rd8(r, v);
         chk($sformatf("blink1_row%0d", r), 32'(v),
             (r >= 2 && r <= 4) ? 32'h08 : 32'h00);
      end
      gen8_run(n);
      for (int r = 0; r < 8; r++) begin
         rd8(r, v);
         chk($sformatf("blink2_row%0d", r), 32'(v),
             (r == 3) ? 32'h1C : 32'h00);
      end
      chk("blink_gen", 32'(gen8), 2);

      // Plumbing on the 4-row grid
      ld4(0, 8'hA1); ld4(1, 8'hB2); ld4(2, 8'hC3); ld4(3, 8'hD4);
      rd4(2, v);
      chk("idle_rd_row2", 32'(v), 32'hC3);
      exp_seq[0] = top;   exp_seq[1] = 8'hA1; exp_seq[2] = 8'hB2;
      exp_seq[3] = 8'hC3; exp_seq[4] = 8'hD4; exp_seq[5] = bot;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      chk("seq_k0", 32'(in4), 32'(exp_seq[0]));
      chk("run_busy", 32'(busy4), 1);
      for (int j = 1; j < 6; j++) begin
         tick();
         n++;
         if (j == 3) begin ld_en4 = 1'b0; start4 = 1'b0; end
         chk($sformatf("seq_k%0d", j), 32'(in4), 32'(exp_seq[j]));
         if (j == 2) begin
            ld_en4 = 1'b1; ld_addr4 = 2'd1; ld_data4 = 8'hFF; start4 = 1'b1;
         end
      end
      while (!done4 && n < 40) begin
         tick();
         n++;
      end
      chk("done_cycle", n, 7);
      pulses = 1;
      for (int j = 0; j < 12; j++) begin
         tick();
         if (done4) pulses++;
      end
      chk("done_pulses", pulses, 1);
      chk("idle_busy", 32'(busy4), 0);
      chk("gen_after_one", 32'(gen4), 1);
      for (int r = 0; r < 4; r++) begin
         rd4(r, v);
         chk($sformatf("plumb_row%0d", r), 32'(v), 32'(exp_seq[r+1]));
      end

      ld4(1, 8'hFF);
      rd4(1, v);
      chk("idle_ld_row1", 32'(v), 32'hFF);

      // Load and start in the same cycle: row 0 must stream the new value
      start4 = 1'b1; ld_en4 = 1'b1; ld_addr4 = 2'd0; ld_data4 = 8'h5A;
      tick();
      start4 = 1'b0; ld_en4 = 1'b0;
      tick();
      chk("start_ld_k1", 32'(in4), 32'h5A);
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("midrun_rst_busy", 32'(busy4), 0);
      chk("midrun_rst_arr_in", 32'(in4), 0);
      tick();
      rst = 1'b0;
      tick();
      chk("midrun_rst_gen", 32'(gen4), 0);
      for (int r = 0; r < 4; r++) begin
         rd4(r, v);
         chk($sformatf("midrun_rst_row%0d", r), 32'(v), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
